// File: rtl/write_back_stage.sv
// Write-back stage: selects ALU/PC+4/imm/zero or formats a load word, and
// retires one instruction per cycle, stalling in WAIT_MEM for late load data.
module write_back_stage #(
  parameter int XLEN    = 32,
  parameter int REG_AW  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_ma_valid,
  output logic              o_ma_ready,
  input  logic              i_ma_mem_to_reg,
  input  logic [1:0]        i_ma_rw_sel,
  input  logic [2:0]        i_ma_funct3,
  input  logic [XLEN-1:0]   i_ma_result,
  input  logic [XLEN-1:0]   i_ma_pc_plus_4,
  input  logic [XLEN-1:0]   i_ma_imm,
  input  logic [REG_AW-1:0] i_ma_rd,
  input  logic              i_ma_reg_write,
  input  logic              i_mem_rvalid,
  input  logic [XLEN-1:0]   i_mem_rdata,
  output logic              o_wb_valid,
  output logic              o_wb_we,
  output logic [REG_AW-1:0] o_wb_rd,
  output logic [XLEN-1:0]   o_wb_data,
  output logic              o_wb_err
);

  localparam int OFFW = $clog2(XLEN / 8);

  typedef enum logic {IDLE, WAIT_MEM} state_t;

  state_t            state, state_nxt;
  logic [7:0]        tmo_cnt, cnt_nxt, cnt_inc;
  logic [2:0]        cap_funct3;
  logic [OFFW-1:0]   cap_off;
  logic [REG_AW-1:0] cap_rd;
  logic              cap_reg_write;

  logic              cap_load;
  logic              ret, ret_err, ret_rw;
  logic [REG_AW-1:0] ret_rd;
  logic [XLEN-1:0]   ret_data, src_data;
  logic [OFFW-1:0]   in_off;

  function automatic logic load_bad(input logic [2:0] f3, input logic [OFFW-1:0] off);
    logic bad;
    case (f3)
      3'b000, 3'b100: bad = 1'b0;
      3'b001, 3'b101: bad = off[0];
      3'b010:         bad = |off[1:0];
      3'b110:         bad = (XLEN != 64) || (|off[1:0]);
      3'b011:         bad = (XLEN != 64) || (|off);
      default:        bad = 1'b1;
    endcase
    return bad;
  endfunction

  function automatic logic [XLEN-1:0] load_fmt(input logic [2:0] f3,
                                               input logic [OFFW-1:0] off,
                                               input logic [XLEN-1:0] rdata);
    logic [XLEN-1:0] sh;
    logic [XLEN-1:0] res;
    sh = rdata >> {off, 3'b000};
    case (f3)
      3'b000:  res = XLEN'($signed(sh[7:0]));
      3'b100:  res = XLEN'(sh[7:0]);
      3'b001:  res = XLEN'($signed(sh[15:0]));
      3'b101:  res = XLEN'(sh[15:0]);
      3'b010:  res = XLEN'($signed(sh[31:0]));
      3'b110:  res = XLEN'(sh[31:0]);
      default: res = sh;
    endcase
    return res;
  endfunction

  assign o_ma_ready = (state == IDLE);
  assign in_off     = i_ma_result[OFFW-1:0];
  assign cnt_inc    = tmo_cnt + 8'd1;

  always_comb begin
    case (i_ma_rw_sel)
      2'b00:   src_data = i_ma_result;
      2'b01:   src_data = i_ma_pc_plus_4;
      2'b10:   src_data = i_ma_imm;
      default: src_data = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = tmo_cnt;
    cap_load  = 1'b0;
    ret       = 1'b0;
    ret_err   = 1'b0;
    ret_rd    = cap_rd;
    ret_rw    = cap_reg_write;
    ret_data  = o_wb_data;
    case (state)
      IDLE: begin
        if (i_ma_valid) begin
          cap_load = 1'b1;
          ret_rd   = i_ma_rd;
          ret_rw   = i_ma_reg_write;
          if (!i_ma_mem_to_reg) begin
            ret      = 1'b1;
            ret_data = src_data;
          end else if (load_bad(i_ma_funct3, in_off)) begin
            ret     = 1'b1;
            ret_err = 1'b1;
          end else if (i_mem_rvalid) begin
            ret      = 1'b1;
            ret_data = load_fmt(i_ma_funct3, in_off, i_mem_rdata);
          end else begin
            state_nxt = WAIT_MEM;
            cnt_nxt   = '0;
          end
        end
      end
      WAIT_MEM: begin
        // Data arriving on the timeout cycle takes priority over the error.
        if (i_mem_rvalid) begin
          ret       = 1'b1;
          ret_data  = load_fmt(cap_funct3, cap_off, i_mem_rdata);
          state_nxt = IDLE;
        end else if (cnt_inc == 8'(TIMEOUT)) begin
          ret       = 1'b1;
          ret_err   = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= IDLE;
      tmo_cnt       <= '0;
      cap_funct3    <= '0;
      cap_off       <= '0;
      cap_rd        <= '0;
      cap_reg_write <= 1'b0;
      o_wb_valid    <= 1'b0;
      o_wb_we       <= 1'b0;
      o_wb_err      <= 1'b0;
      o_wb_rd       <= '0;
      o_wb_data     <= '0;
    end else begin
      state      <= state_nxt;
      tmo_cnt    <= cnt_nxt;
      o_wb_valid <= ret;
      o_wb_err   <= ret_err;
      o_wb_we    <= ret & ret_rw & (ret_rd != '0) & ~ret_err;
      if (cap_load) begin
        cap_funct3    <= i_ma_funct3;
        cap_off       <= in_off;
        cap_rd        <= i_ma_rd;
        cap_reg_write <= i_ma_reg_write;
      end
      if (ret) begin
        o_wb_rd   <= ret_rd;
        o_wb_data <= ret_data;
      end
    end
  end

endmodule

// File: tb/tb_write_back_stage.sv
// Randomised scoreboard bench for write_back_stage (XLEN=32, TIMEOUT=15).
module tb_write_back_stage;

  localparam int TMO = 15;

  logic        clk;
  logic        rst_n;
  logic        i_ma_valid;
  logic        o_ma_ready;
  logic        i_ma_mem_to_reg;
  logic [1:0]  i_ma_rw_sel;
  logic [2:0]  i_ma_funct3;
  logic [31:0] i_ma_result;
  logic [31:0] i_ma_pc_plus_4;
  logic [31:0] i_ma_imm;
  logic [4:0]  i_ma_rd;
  logic        i_ma_reg_write;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        o_wb_valid;
  logic        o_wb_we;
  logic [4:0]  o_wb_rd;
  logic [31:0] o_wb_data;
  logic        o_wb_err;

  typedef struct {
    int          cyc;
    logic        err;
    logic        we;
    logic [4:0]  rd;
    logic [31:0] data;
  } exp_t;

  exp_t sbq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  write_back_stage #(.XLEN(32), .REG_AW(5), .TIMEOUT(TMO)) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_ma_valid     (i_ma_valid),
    .o_ma_ready     (o_ma_ready),
    .i_ma_mem_to_reg(i_ma_mem_to_reg),
    .i_ma_rw_sel    (i_ma_rw_sel),
    .i_ma_funct3    (i_ma_funct3),
    .i_ma_result    (i_ma_result),
    .i_ma_pc_plus_4 (i_ma_pc_plus_4),
    .i_ma_imm       (i_ma_imm),
    .i_ma_rd        (i_ma_rd),
    .i_ma_reg_write (i_ma_reg_write),
    .i_mem_rvalid   (i_mem_rvalid),
    .i_mem_rdata    (i_mem_rdata),
    .o_wb_valid     (o_wb_valid),
    .o_wb_we        (o_wb_we),
    .o_wb_rd        (o_wb_rd),
    .o_wb_data      (o_wb_data),
    .o_wb_err       (o_wb_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference load semantics: size from funct3, alignment by address modulo size.
  task automatic ref_load(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] rdata,
                          output logic bad, output logic [31:0] data);
    int unsigned size;
    int unsigned off;
    logic [31:0] v;
    logic        sgn;
    sgn  = (f3 < 3'd4);
    size = 0;
    if (f3 == 3'd0 || f3 == 3'd4) size = 1;
    if (f3 == 3'd1 || f3 == 3'd5) size = 2;
    if (f3 == 3'd2) size = 4;
    bad  = (size == 0) || ((addr % size) != 0);
    off  = addr % 4;
    v    = rdata >> (8 * off);
    data = v;
    if (size == 1) begin
      data = v & 32'hFF;
      if (sgn && v[7]) data = data | 32'hFFFF_FF00;
    end else if (size == 2) begin
      data = v & 32'hFFFF;
      if (sgn && v[15]) data = data | 32'hFFFF_0000;
    end
  endtask

  // delay: 0 = rvalid with accept, n = rvalid in the n-th waiting cycle.
  task automatic txn(input logic m2r, input logic [1:0] rws, input logic [2:0] f3,
                     input logic [31:0] res, input logic [31:0] pc4, input logic [31:0] imm,
                     input logic [4:0] rd, input logic rw, input logic [31:0] rdata,
                     input int delay);
    exp_t        e;
    logic        bad;
    logic [31:0] ld;
    int          k;
    int          lat;
    @(posedge clk); #1;
    k = cyc;
    i_ma_valid      = 1'b1;
    i_ma_mem_to_reg = m2r;
    i_ma_rw_sel     = rws;
    i_ma_funct3     = f3;
    i_ma_result     = res;
    i_ma_pc_plus_4  = pc4;
    i_ma_imm        = imm;
    i_ma_rd         = rd;
    i_ma_reg_write  = rw;
    i_mem_rdata     = rdata;
    e.rd  = rd;
    e.cyc = k + 1;
    e.err = 1'b0;
    if (!m2r) begin
      i_mem_rvalid = 1'($urandom_range(0, 1));
      case (rws)
        2'd0:    e.data = res;
        2'd1:    e.data = pc4;
        2'd2:    e.data = imm;
        default: e.data = 32'h0;
      endcase
      e.we = rw && (rd != 0);
      sbq.push_back(e);
      return;
    end
    ref_load(f3, res, rdata, bad, ld);
    e.data = ld;
    if (bad) begin
      i_mem_rvalid = 1'($urandom_range(0, 1));
      e.err = 1'b1;
      e.we  = 1'b0;
      sbq.push_back(e);
      return;
    end
    if (delay == 0) begin
      i_mem_rvalid = 1'b1;
      e.we = rw && (rd != 0);
      sbq.push_back(e);
      return;
    end
    i_mem_rvalid = 1'b0;
    lat   = (delay <= TMO) ? delay : TMO;
    e.cyc = k + lat + 1;
    e.err = (delay > TMO);
    e.we  = !e.err && rw && (rd != 0);
    sbq.push_back(e);
    for (int j = 1; j <= lat; j++) begin
      @(posedge clk); #1;
      if (j == 1) begin
        i_ma_valid  = 1'b0;
        i_ma_result = $urandom;
      end
      chk("ready_wait", 32'(o_ma_ready), 32'd0);
      if (j == delay) i_mem_rvalid = 1'b1;
    end
    @(posedge clk); #1;
    i_mem_rvalid = 1'b0;
    chk("ready_after", 32'(o_ma_ready), 32'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      i_ma_valid   = 1'b0;
      i_mem_rvalid = 1'($urandom_range(0, 1));
      i_mem_rdata  = $urandom;
    end
    @(posedge clk); #1;
    i_mem_rvalid = 1'b0;
  endtask

  // Monitor: pops the scoreboard on every retire and checks timing and payload.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (o_wb_valid) begin
        if (sbq.size() == 0) begin
          chk("unexpected_retire", {27'd0, o_wb_rd}, 32'hFFFF_FFFF);
        end else begin
          e = sbq.pop_front();
          chk("retire_cycle", 32'(cyc), 32'(e.cyc));
          chk("err", 32'(o_wb_err), 32'(e.err));
          chk("we", 32'(o_wb_we), 32'(e.we));
          chk("rd", {27'd0, o_wb_rd}, {27'd0, e.rd});
          if (!e.err) chk("data", o_wb_data, e.data);
        end
      end else begin
        chk("idle_flags", {30'd0, o_wb_we, o_wb_err}, 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic        m2r;
    logic [2:0]  f3;
    int          r;
    int          dly;
    rst_n = 1'b1;
    i_ma_valid = 1'b0; i_ma_mem_to_reg = 1'b0; i_ma_rw_sel = '0; i_ma_funct3 = '0;
    i_ma_result = '0; i_ma_pc_plus_4 = '0; i_ma_imm = '0; i_ma_rd = '0;
    i_ma_reg_write = 1'b0; i_mem_rvalid = 1'b0; i_mem_rdata = '0;
    #1 rst_n = 1'b0;
    #22;
    chk("rst_valid", 32'(o_wb_valid), 32'd0);
    chk("rst_we_err", {30'd0, o_wb_we, o_wb_err}, 32'd0);
    chk("rst_rd", {27'd0, o_wb_rd}, 32'd0);
    chk("rst_data", o_wb_data, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_ready", 32'(o_ma_ready), 32'd1);

    // Non-load sources, back to back.
    txn(0, 2'b00, 3'd0, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'h1234_5678, 5'd5, 1, 32'h0, 0);
    txn(0, 2'b01, 3'd0, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'h1234_5678, 5'd5, 1, 32'h0, 0);
    txn(0, 2'b10, 3'd0, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'h1234_5678, 5'd5, 1, 32'h0, 0);
    txn(0, 2'b11, 3'd0, 32'hBBBB_BBBB, 32'hCCCC_CCCC, 32'h1234_5678, 5'd5, 1, 32'h0, 0);
    // Load formatting with data in the accept cycle.
    txn(1, 2'b00, 3'd0, 32'h1001, 32'h0, 32'h0, 5'd7, 1, 32'hAAAA_80AA, 0);
    txn(1, 2'b00, 3'd4, 32'h1001, 32'h0, 32'h0, 5'd7, 1, 32'hAAAA_80AA, 0);
    txn(1, 2'b00, 3'd1, 32'h1002, 32'h0, 32'h0, 5'd7, 1, 32'hAAAA_80AA, 0);
    txn(1, 2'b00, 3'd5, 32'h1002, 32'h0, 32'h0, 5'd7, 1, 32'hAAAA_80AA, 0);
    // rd=0, misaligned LW, illegal funct3 values.
    txn(0, 2'b00, 3'd0, 32'h5555_5555, 32'h0, 32'h0, 5'd0, 1, 32'h0, 0);
    txn(1, 2'b00, 3'd2, 32'h1002, 32'h0, 32'h0, 5'd9, 1, 32'hAAAA_80AA, 0);
    txn(1, 2'b00, 3'd7, 32'h1000, 32'h0, 32'h0, 5'd9, 1, 32'hAAAA_80AA, 0);
    txn(1, 2'b00, 3'd6, 32'h1000, 32'h0, 32'h0, 5'd9, 1, 32'hAAAA_80AA, 0);
    txn(1, 2'b00, 3'd3, 32'h1000, 32'h0, 32'h0, 5'd9, 1, 32'hAAAA_80AA, 0);
    idle(2);
    // Late data, timeout, and data on the timeout cycle.
    txn(1, 2'b00, 3'd2, 32'h2000, 32'h0, 32'h0, 5'd3, 1, 32'hDEAD_BEEF, 3);
    txn(1, 2'b00, 3'd2, 32'h2004, 32'h0, 32'h0, 5'd4, 1, 32'h0BAD_F00D, TMO + 5);
    txn(1, 2'b00, 3'd0, 32'h2007, 32'h0, 32'h0, 5'd6, 1, 32'h8012_3456, TMO);
    idle(3);

    for (int n = 0; n < 150; n++) begin
      m2r = 1'($urandom_range(0, 1));
      f3  = 3'($urandom_range(0, 7));
      r   = int'($urandom_range(0, 9));
      dly = (r < 3) ? 0 : ((r < 9) ? r - 2 : TMO + 3);
      txn(m2r, 2'($urandom_range(0, 3)), f3, $urandom, $urandom, $urandom,
          5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), $urandom, dly);
      if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
    end
    idle(2);

    // Reset while waiting for memory: pending load is dropped.
    txn(0, 2'b00, 3'd0, 32'h7777_7777, 32'h0, 32'h0, 5'd12, 1, 32'h0, 0);
    @(posedge clk); #1;
    i_ma_valid = 1'b1; i_ma_mem_to_reg = 1'b1; i_ma_funct3 = 3'd2;
    i_ma_result = 32'h3000; i_ma_rd = 5'd8; i_ma_reg_write = 1'b1; i_mem_rvalid = 1'b0;
    @(posedge clk); #1;
    i_ma_valid = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(o_wb_valid), 32'd0);
    chk("midrst_we_err", {30'd0, o_wb_we, o_wb_err}, 32'd0);
    chk("midrst_rd", {27'd0, o_wb_rd}, 32'd0);
    chk("midrst_data", o_wb_data, 32'd0);
    chk("midrst_ready", 32'(o_ma_ready), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      i_mem_rvalid = 1'b1;
      i_mem_rdata  = 32'hFEED_FACE;
    end
    @(posedge clk); #1;
    i_mem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("drain", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/write_back_stage.md
WRITE_BACK_STAGE -- requirements
Module: write_back_stage

Interface
- REQ-001 Parameters (name, default, meaning):
  - XLEN, 32, datapath width; legal values 32 or 64.
  - REG_AW, 5, register-address width.
  - TIMEOUT, 15, maximum WAIT_MEM cycles without a memory response; legal range 1..255.
- REQ-002 Ports (name, direction, width, meaning):
  - i_clk, in, 1, clock.
  - i_rst_n, in, 1, asynchronous active-low reset.
  - i_ma_valid, in, 1, MA stage presents an instruction.
  - o_ma_ready, out, 1, stage accepts an instruction.
  - i_ma_mem_to_reg, in, 1, load result selected.
  - i_ma_rw_sel, in, 2, non-load source: 00 ALU result, 01 PC+4, 10 immediate, 11 zero.
  - i_ma_funct3, in, 3, load size and sign.
  - i_ma_result, in, XLEN, ALU result or load address.
  - i_ma_pc_plus_4, in, XLEN, PC+4.
  - i_ma_imm, in, XLEN, immediate.
  - i_ma_rd, in, REG_AW, destination register.
  - i_ma_reg_write, in, 1, instruction writes rd.
  - i_mem_rvalid, in, 1, load data valid.
  - i_mem_rdata, in, XLEN, raw aligned memory word.
  - o_wb_valid, out, 1, one-cycle retire pulse.
  - o_wb_we, out, 1, register-file write enable.
  - o_wb_rd, out, REG_AW, write address.
  - o_wb_data, out, XLEN, write data.
  - o_wb_err, out, 1, one-cycle pulse on misalignment, illegal funct3 or timeout.
- REQ-003 Clock is i_clk only; reset is i_rst_n, asynchronous assert, active-low.

Function
- REQ-004 FSM states SHALL be IDLE and WAIT_MEM; o_ma_ready SHALL be 1 in IDLE and 0 in WAIT_MEM.
- REQ-005 Accept occurs when i_ma_valid and o_ma_ready are both 1; all i_ma_* SHALL be captured at accept.
- REQ-006 Non-load accept: the cycle after accept, o_wb_valid = 1 and o_wb_data = source per i_ma_rw_sel; state stays IDLE; back-to-back accepts sustain 1 instruction per cycle.
- REQ-007 Load accept with i_mem_rvalid = 1 in the same cycle SHALL retire the next cycle like REQ-006; without i_mem_rvalid, the next state SHALL be WAIT_MEM.
- REQ-008 In WAIT_MEM, i_mem_rvalid = 1 SHALL cause retire the following cycle and return to IDLE.
- REQ-009 Byte offset is i_ma_result[log2(XLEN/8)-1:0].
  - funct3 000 LB / 100 LBU: byte at offset, sign- or zero-extended to XLEN.
  - 001 LH / 101 LHU: halfword at offset.
  - 010 LW: word at offset; 110 LWU: zero-extended word.
  - 011 LD: full XLEN.
  - LWU and LD are legal only when XLEN = 64; 111 is always illegal.
- REQ-010 Misaligned load or illegal funct3 SHALL retire with o_wb_err = 1, o_wb_we = 0, without waiting for memory.
- REQ-011 The timeout counter SHALL clear on entering WAIT_MEM and increment each WAIT_MEM cycle without i_mem_rvalid. On reaching TIMEOUT, it SHALL return to IDLE with a one-cycle o_wb_err, o_wb_valid = 1 and o_wb_we = 0. If i_mem_rvalid arrives in that same cycle, data wins and no error is raised.
- REQ-012 o_wb_we = o_wb_valid & captured reg_write & (rd != 0) & ~o_wb_err; o_wb_rd and o_wb_data SHALL be held stable while o_wb_valid = 0.
- REQ-013 i_mem_rvalid while no load is pending SHALL be ignored.
- REQ-014 o_wb_valid, o_wb_we and o_wb_err are registered; each SHALL be high for exactly one cycle per retire.

Reset
- REQ-015 While i_rst_n = 0:
  - state = IDLE, counter = 0.
  - o_wb_valid, o_wb_we and o_wb_err = 0.
  - o_wb_rd = 0, o_wb_data = 0.
  - o_ma_ready SHALL be 1 from the first clock edge after release.
- REQ-016 Reset during WAIT_MEM SHALL abandon the pending load with no write and no error pulse; a late i_mem_rvalid after release SHALL be ignored.

Verification
- REQ-017 Non-load: rw_sel = 00, result = BBBBBBBB, rd = 5, reg_write = 1 -> next cycle valid = 1, we = 1, rd = 5, data = BBBBBBBB. Repeat with rw_sel 01, 10 and 11 -> CCCCCCCC (PC+4), imm, 00000000.
- REQ-018 Loads, XLEN = 32, address 0x1001, rdata = AAAA80AA, rvalid same cycle:
  - LB -> FFFFFF80.
  - LBU -> 00000080.
  - LH at address 0x1002 -> FFFFAAAA.
  - LHU at address 0x1002 -> 0000AAAA.
- REQ-019 Load with rvalid arriving 3 cycles after accept -> o_ma_ready low 3 cycles; retire 1 cycle after rvalid; total latency 4 cycles.
- REQ-020 Timeout: TIMEOUT = 15, no rvalid -> err and valid pulse after 15 WAIT_MEM cycles, we = 0, ready = 1 the cycle after. Also check rvalid on cycle 15 -> normal write, err = 0.
- REQ-021 rd = 0, and separately LW at address 0x1002 -> valid = 1, we = 0; err = 1 only for the misaligned LW.
- REQ-022 Reset mid-operation: assert i_rst_n = 0 at WAIT_MEM cycle 2 -> outputs zero immediately; rvalid after release -> no retire.
